freq_sweep_ctrl: RTL and testbench

- Resonance-search engine for the SWIPT transmitter. It steps the drive frequency from F_START to F_STOP in F_STEP increments, waits for the analog network to settle at each point, and averages the 12-bit ADC reading.
- It tracks the frequency with the highest mean reading. It feeds new_freq / best_freq / done to the top-level program FSM, which drives SwiptOut with new_freq while done is low and latches best_freq when done rises.

---
 rtl/swipt_pkg.sv | 19 +
 rtl/adc_block_avg.sv | 58 +++++
 rtl/freq_sweep_ctrl.sv | 131 +++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/swipt_pkg.sv
// Shared SWIPT definitions: bus widths, sweep FSM states and power-on defaults
// used by the sweep engine, SwiptOut and the top-level program FSM.
package swipt_pkg;

  localparam int FREQ_W = 20;
  localparam int ADC_W  = 12;

  localparam logic [FREQ_W-1:0] DEF_FREQ = 20'd35000;
  localparam logic [ADC_W-1:0]  DEF_DUTY = 12'd200;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ACCUM,
    EVAL,
    DONE
  } sweep_state_t;

endpackage

// File: rtl/adc_block_avg.sv
// Block averager: sums 2^AVG_LOG2 consecutive ADC samples while enabled and
// presents the truncated mean with a one-cycle valid after the last sample.
module adc_block_avg
  import swipt_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [ADC_W-1:0] adc_i,
  output logic             last_o,
  output logic [ADC_W-1:0] mean_o,
  output logic             valid_o
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  // The final sample is still added on the cycle last_o is high.
  assign last_o = en_i && (cnt_q == CNT_MAX);

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      acc_d   = acc_q + ACC_W'(adc_i);
      cnt_d   = last_o ? '0 : cnt_q + CNT_W'(1);
      valid_d = last_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign mean_o  = acc_q[ACC_W-1:AVG_LOG2];
  assign valid_o = valid_q;

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Resonance search: steps the drive frequency across the band, averages the ADC
// after settling at each point, and keeps the frequency with the largest mean.
module freq_sweep_ctrl
  import swipt_pkg::*;
#(
  parameter logic [FREQ_W-1:0] F_START    = 20'd30000,
  parameter logic [FREQ_W-1:0] F_STOP     = 20'd40000,
  parameter logic [FREQ_W-1:0] F_STEP     = 20'd500,
  parameter logic [15:0]       SETTLE_CYC = 16'd1000,
  parameter int                AVG_LOG2   = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable_i,
  input  logic [ADC_W-1:0]  adc_i,
  output logic [FREQ_W-1:0] new_freq_o,
  output logic [FREQ_W-1:0] best_freq_o,
  output logic [ADC_W-1:0]  best_amp_o,
  output logic              done_o
);

  sweep_state_t      state_q, state_d;
  logic [15:0]       settleCnt_q, settleCnt_d;
  logic [FREQ_W-1:0] newFreq_q, newFreq_d;
  logic [FREQ_W-1:0] bestFreq_q, bestFreq_d;
  logic [ADC_W-1:0]  bestAmp_q, bestAmp_d;
  logic              done_q, done_d;

  logic              abort;
  logic              avgClear, avgEn, avgLast, avgValid;
  logic [ADC_W-1:0]  avgMean;
  logic [FREQ_W:0]   nextFreq;

  // Dropping enable anywhere outside IDLE discards the partial sweep.
  assign abort    = (state_q != IDLE) && !enable_i;
  assign avgClear = abort || !((state_q == ACCUM) || (state_q == EVAL));
  assign avgEn    = (state_q == ACCUM);
  assign nextFreq = {1'b0, newFreq_q} + {1'b0, F_STEP};

  adc_block_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk    (clk),
    .nrst   (nrst),
    .clear_i(avgClear),
    .en_i   (avgEn),
    .adc_i  (adc_i),
    .last_o (avgLast),
    .mean_o (avgMean),
    .valid_o(avgValid)
  );

  always_comb begin
    state_d     = state_q;
    settleCnt_d = settleCnt_q;
    newFreq_d   = newFreq_q;
    bestFreq_d  = bestFreq_q;
    bestAmp_d   = bestAmp_q;
    done_d      = done_q;
    if (abort) begin
      state_d     = IDLE;
      settleCnt_d = '0;
      newFreq_d   = F_START;
      bestFreq_d  = F_START;
      bestAmp_d   = '0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_d     = SETTLE;
            settleCnt_d = '0;
          end
        end
        SETTLE: begin
          if (settleCnt_q == SETTLE_CYC - 16'd1) begin
            settleCnt_d = '0;
            state_d     = ACCUM;
          end else begin
            settleCnt_d = settleCnt_q + 16'd1;
          end
        end
        ACCUM: begin
          if (avgLast) state_d = EVAL;
        end
        EVAL: begin
          // Strict compare keeps the lower frequency on a tie.
          if (avgValid && (avgMean > bestAmp_q)) begin
            bestAmp_d  = avgMean;
            bestFreq_d = newFreq_q;
          end
          if (nextFreq > {1'b0, F_STOP}) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            newFreq_d   = nextFreq[FREQ_W-1:0];
            settleCnt_d = '0;
            state_d     = SETTLE;
          end
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      settleCnt_q <= '0;
      newFreq_q   <= F_START;
      bestFreq_q  <= F_START;
      bestAmp_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settleCnt_q <= settleCnt_d;
      newFreq_q   <= newFreq_d;
      bestFreq_q  <= bestFreq_d;
      bestAmp_q   <= bestAmp_d;
      done_q      <= done_d;
    end
  end

  assign new_freq_o  = newFreq_q;
  assign best_freq_o = bestFreq_q;
  assign best_amp_o  = bestAmp_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl with a small 4-point sweep; expected
// results come from a per-point averaging model over the driven ADC stream.
module tb_freq_sweep_ctrl;
  import swipt_pkg::*;

  localparam int F0  = 1000;
  localparam int F1  = 1300;
  localparam int FS  = 100;
  localparam int SPP = 9;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        enable_i = 1'b0;
  logic [11:0] adc_i = 12'd0;
  logic [19:0] new_freq_o, best_freq_o;
  logic [11:0] best_amp_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;

  // stim[k] is the ADC code presented just before the k-th edge after enable is sampled.
  logic [11:0] stim [1:36];

  freq_sweep_ctrl #(
    .F_START(20'd1000), .F_STOP(20'd1300), .F_STEP(20'd100),
    .SETTLE_CYC(16'd4), .AVG_LOG2(2)
  ) dut (
    .clk(clk), .nrst(nrst), .enable_i(enable_i), .adc_i(adc_i),
    .new_freq_o(new_freq_o), .best_freq_o(best_freq_o),
    .best_amp_o(best_amp_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Each point: 4 settle cycles, 4 averaged samples, 1 evaluation cycle.
  function automatic void model_sweep(output logic [19:0] bf, output logic [11:0] ba,
                                      output logic [19:0] nf);
    int f;
    int p;
    int sum;
    f  = F0;
    p  = 0;
    bf = 20'(F0);
    ba = 12'd0;
    while (1) begin
      sum = 0;
      for (int s = 0; s < 4; s++) sum += int'(stim[p*SPP + 5 + s]);
      if ((sum / 4) > int'(ba)) begin
        ba = 12'(sum / 4);
        bf = 20'(f);
      end
      if (f + FS > F1) break;
      f += FS;
      p++;
    end
    nf = 20'(f);
  endfunction

  task automatic fill_points(input int a0, input int a1, input int a2, input int a3);
    for (int k = 1; k <= 36; k++) begin
      case ((k - 1) / SPP)
        0: stim[k] = 12'(a0);
        1: stim[k] = 12'(a1);
        2: stim[k] = 12'(a2);
        default: stim[k] = 12'(a3);
      endcase
    end
  endtask

  task automatic fill_random();
    for (int k = 1; k <= 36; k++) stim[k] = 12'($urandom_range(1, 4095));
  endtask

  task automatic go_idle();
    enable_i = 1'b0;
    adc_i = 12'($urandom_range(0, 4095));
    @(posedge clk); #1;
  endtask

  task automatic run_sweep(output int doneEdge);
    enable_i = 1'b1;
    adc_i = 12'($urandom_range(0, 4095));
    @(posedge clk); #1;
    doneEdge = -1;
    for (int k = 1; k <= 60; k++) begin
      adc_i = (k <= 36) ? stim[k] : 12'd0;
      @(posedge clk); #1;
      if (done_o === 1'b1) begin
        doneEdge = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    enable_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (new_freq_o !== 20'd1000) begin errors++; $display("[TB] FAIL reset new_freq: got %0d expected 1000", new_freq_o); end
    checks++; if (best_freq_o !== 20'd1000) begin errors++; $display("[TB] FAIL reset best_freq: got %0d expected 1000", best_freq_o); end
    checks++; if (best_amp_o !== 12'd0) begin errors++; $display("[TB] FAIL reset best_amp: got %0d expected 0", best_amp_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %0d expected 0", done_o); end
    enable_i = 1'b0;
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pattern(input string name, input int a0, input int a1,
                              input int a2, input int a3);
    int de;
    logic [19:0] bf, nf;
    logic [11:0] ba;
    fill_points(a0, a1, a2, a3);
    model_sweep(bf, ba, nf);
    run_sweep(de);
    checks++; if (de != 36) begin errors++; $display("[TB] FAIL %s done_edge: got %0d expected 36", name, de); end
    checks++; if (best_freq_o !== bf) begin errors++; $display("[TB] FAIL %s best_freq: got %0d expected %0d", name, best_freq_o, bf); end
    checks++; if (best_amp_o !== ba) begin errors++; $display("[TB] FAIL %s best_amp: got %0d expected %0d", name, best_amp_o, ba); end
    checks++; if (new_freq_o !== nf) begin errors++; $display("[TB] FAIL %s new_freq: got %0d expected %0d", name, new_freq_o, nf); end
    go_idle();
  endtask

  task automatic test_truncate();
    int de;
    logic [19:0] bf, nf;
    logic [11:0] ba;
    fill_points(0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) stim[k] = 12'($urandom_range(0, 4095));
    stim[5] = 12'd10; stim[6] = 12'd20; stim[7] = 12'd30; stim[8] = 12'd41;
    model_sweep(bf, ba, nf);
    run_sweep(de);
    checks++; if (de != 36) begin errors++; $display("[TB] FAIL trunc done_edge: got %0d expected 36", de); end
    checks++; if (best_amp_o !== ba) begin errors++; $display("[TB] FAIL trunc best_amp: got %0d expected %0d", best_amp_o, ba); end
    checks++; if (best_freq_o !== bf) begin errors++; $display("[TB] FAIL trunc best_freq: got %0d expected %0d", best_freq_o, bf); end
    go_idle();
  endtask

  task automatic test_random();
    int de;
    logic [19:0] bf, nf;
    logic [11:0] ba;
    for (int it = 0; it < 6; it++) begin
      fill_random();
      model_sweep(bf, ba, nf);
      run_sweep(de);
      checks++; if (de != 36) begin errors++; $display("[TB] FAIL rand%0d done_edge: got %0d expected 36", it, de); end
      checks++; if (best_freq_o !== bf) begin errors++; $display("[TB] FAIL rand%0d best_freq: got %0d expected %0d", it, best_freq_o, bf); end
      checks++; if (best_amp_o !== ba) begin errors++; $display("[TB] FAIL rand%0d best_amp: got %0d expected %0d", it, best_amp_o, ba); end
      checks++; if (new_freq_o !== nf) begin errors++; $display("[TB] FAIL rand%0d new_freq: got %0d expected %0d", it, new_freq_o, nf); end
      go_idle();
    end
  endtask

  task automatic test_abort();
    int de;
    logic [19:0] bf, nf;
    logic [11:0] ba;
    fill_points(3000, 1500, 2500, 100);
    enable_i = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      adc_i = stim[k];
      @(posedge clk); #1;
      if (k == 9) begin
        checks++; if (new_freq_o !== 20'd1100) begin errors++; $display("[TB] FAIL abort pre new_freq: got %0d expected 1100", new_freq_o); end
      end
    end
    go_idle();
    checks++; if (new_freq_o !== 20'd1000) begin errors++; $display("[TB] FAIL abort new_freq: got %0d expected 1000", new_freq_o); end
    checks++; if (best_amp_o !== 12'd0) begin errors++; $display("[TB] FAIL abort best_amp: got %0d expected 0", best_amp_o); end
    checks++; if (best_freq_o !== 20'd1000) begin errors++; $display("[TB] FAIL abort best_freq: got %0d expected 1000", best_freq_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL abort done: got %0d expected 0", done_o); end
    fill_random();
    model_sweep(bf, ba, nf);
    run_sweep(de);
    checks++; if (de != 36) begin errors++; $display("[TB] FAIL abort restart done_edge: got %0d expected 36", de); end
    checks++; if (best_freq_o !== bf) begin errors++; $display("[TB] FAIL abort restart best_freq: got %0d expected %0d", best_freq_o, bf); end
    checks++; if (best_amp_o !== ba) begin errors++; $display("[TB] FAIL abort restart best_amp: got %0d expected %0d", best_amp_o, ba); end
    go_idle();
  endtask

  task automatic test_reset_mid_accum();
    int de;
    logic [19:0] bf, nf;
    logic [11:0] ba;
    fill_random();
    enable_i = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 24; k++) begin
      adc_i = stim[k];
      @(posedge clk); #1;
    end
    nrst = 1'b0;
    @(posedge clk); #1;
    checks++; if (new_freq_o !== 20'd1000) begin errors++; $display("[TB] FAIL midrst new_freq: got %0d expected 1000", new_freq_o); end
    checks++; if (best_freq_o !== 20'd1000) begin errors++; $display("[TB] FAIL midrst best_freq: got %0d expected 1000", best_freq_o); end
    checks++; if (best_amp_o !== 12'd0) begin errors++; $display("[TB] FAIL midrst best_amp: got %0d expected 0", best_amp_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst done: got %0d expected 0", done_o); end
    nrst = 1'b1;
    fill_random();
    model_sweep(bf, ba, nf);
    run_sweep(de);
    checks++; if (de != 36) begin errors++; $display("[TB] FAIL midrst restart done_edge: got %0d expected 36", de); end
    checks++; if (best_freq_o !== bf) begin errors++; $display("[TB] FAIL midrst restart best_freq: got %0d expected %0d", best_freq_o, bf); end
    checks++; if (best_amp_o !== ba) begin errors++; $display("[TB] FAIL midrst restart best_amp: got %0d expected %0d", best_amp_o, ba); end
    go_idle();
  endtask

  task automatic test_hold_release();
    int de;
    logic [19:0] bf, nf;
    logic [11:0] ba;
    fill_random();
    model_sweep(bf, ba, nf);
    run_sweep(de);
    checks++; if (de != 36) begin errors++; $display("[TB] FAIL hold done_edge: got %0d expected 36", de); end
    for (int c = 0; c < 100; c++) begin
      adc_i = 12'($urandom_range(0, 4095));
      @(posedge clk); #1;
      checks++;
      if ({done_o, new_freq_o, best_freq_o, best_amp_o} !== {1'b1, nf, bf, ba}) begin
        errors++;
        $display("[TB] FAIL hold cycle %0d: got done=%0d nf=%0d bf=%0d ba=%0d expected done=1 nf=%0d bf=%0d ba=%0d",
                 c, done_o, new_freq_o, best_freq_o, best_amp_o, nf, bf, ba);
      end
    end
    go_idle();
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL release done: got %0d expected 0", done_o); end
    checks++; if (new_freq_o !== 20'd1000) begin errors++; $display("[TB] FAIL release new_freq: got %0d expected 1000", new_freq_o); end
    checks++; if (best_amp_o !== 12'd0) begin errors++; $display("[TB] FAIL release best_amp: got %0d expected 0", best_amp_o); end
  endtask

  initial begin
    test_reset();
    test_pattern("peak", 100, 300, 900, 200);
    test_pattern("tie", 500, 700, 700, 100);
    test_pattern("flat", 0, 0, 0, 0);
    test_truncate();
    test_random();
    test_abort();
    test_reset_mid_accum();
    test_hold_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
